// File: rtl/data_mem_responder.sv
// Data memory responder: one RV32I load/store at a time against a word array.
// Latency: resp_valid rises LATENCY rising edges after the accepting edge.
// Backpressure: a response is held stable until resp_ready; req_ready is low outside IDLE.
//
// Ports:
//   clk, rst        - clock and asynchronous active-low reset
//   req_valid/ready - request handshake; req_we, req_funct3, req_addr, req_wdata are request fields
//   resp_valid/ready- response handshake; resp_rdata is the extended load data, resp_err flags
//                     misaligned, out-of-range or illegal-funct3 requests
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Storage has no reset: contents are undefined until written.
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          out_of_range;
  logic          illegal;
  logic          misaligned;
  logic          err;
  logic          exec;
  logic [31:0]   old_word;
  logic [31:0]   new_word;
  logic [31:0]   load_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign idx          = addr_q[AW+1:2];
  // Any set bit above the word-index field addresses beyond the array.
  assign out_of_range = (addr_q >> (AW + 2)) != 32'd0;

  // funct3[1:0]: 00 byte, 01 half, 10 word; funct3[2] marks unsigned loads only.
  always_comb begin
    illegal = 1'b0;
    if (funct3_q[1:0] == 2'b11) begin
      illegal = 1'b1;
    end else if (we_q) begin
      illegal = funct3_q[2];
    end else begin
      illegal = (funct3_q == 3'b110);
    end
  end

  assign misaligned = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
  assign err        = illegal || misaligned || out_of_range;

  // The access happens on the last WAIT edge.
  assign exec     = (state == WAIT) && (cnt == 4'd1);
  assign old_word = mem[idx];

  // Sub-word stores merge into the current word so untouched lanes survive.
  always_comb begin
    new_word = old_word;
    case (funct3_q[1:0])
      2'b00:   new_word[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   new_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: new_word = wdata_q;
    endcase
  end

  assign ld_byte = old_word[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = old_word[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_data = old_word;
    case (funct3_q[1:0])
      2'b00:   load_data = funct3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_data = funct3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = old_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (exec && we_q && !err) begin
      mem[idx] <= new_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt       <= 4'(LATENCY);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= err;
            resp_rdata <= (err || we_q) ? 32'd0 : load_data;
          end
        end
        RESP: begin
          // Returning to IDLE here means the earliest next accept is one edge later.
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=2 instance and one LATENCY=1 instance.
// Latency and stall behaviour are checked edge by edge.
// Responses are held with resp_ready low to exercise backpressure.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;

  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

  int tests = 0;
  int fails = 0;
  int lat;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  // Back-to-back table for the LATENCY=1 instance.
  logic        bt_we    [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [2:0]  bt_f3    [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b000};
  logic [31:0] bt_addr  [6] = '{32'h80, 32'h84, 32'h80, 32'h84, 32'h85, 32'h87};
  logic [31:0] bt_wdata [6] = '{32'h11111111, 32'h8222F222, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] bt_exp   [6] = '{32'h0, 32'h0, 32'h11111111, 32'h8222F222, 32'h000000F2, 32'hFFFFFF82};

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    chk1("req_ready_before_accept", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    tick();
    req_valid  = 1'b0;
    chk1("req_ready_after_accept", req_ready, 1'b0);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!resp_valid && n < 20);
  endtask

  task automatic handshake;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk1("resp_valid_cleared", resp_valid, 1'b0);
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    issue(we, f3, a, wd);
    wait_resp(n);
    chk32({tag, "_latency"}, 32'(n), 32'd2);
    chk32({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk1({tag, "_err"}, resp_err, exp_err);
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_funct3 = 0; b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 0;

    // Reset asserted before any clock edge: outputs must clear asynchronously.
    #1 rst = 1'b0;
    #1;
    chk1("reset_req_ready", req_ready, 1'b1);
    chk1("reset_resp_valid", resp_valid, 1'b0);
    chk32("reset_resp_rdata", resp_rdata, 32'd0);
    chk1("reset_resp_err", resp_err, 1'b0);
    chk1("reset_b_req_ready", b_req_ready, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Word store / load round trip.
    txn("sw_40", 1'b1, 3'b010, 32'h40, 32'h12345678, 32'h0, 1'b0);
    txn("lw_40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h12345678, 1'b0);

    // Byte store into lane 1, then every load flavour.
    txn("sb_41", 1'b1, 3'b000, 32'h41, 32'h000000AB, 32'h0, 1'b0);
    txn("lw_40_after_sb", 1'b0, 3'b010, 32'h40, 32'h0, 32'h1234AB78, 1'b0);
    txn("lb_41", 1'b0, 3'b000, 32'h41, 32'h0, 32'hFFFFFFAB, 1'b0);
    txn("lbu_41", 1'b0, 3'b100, 32'h41, 32'h0, 32'h000000AB, 1'b0);
    txn("lh_42", 1'b0, 3'b001, 32'h42, 32'h0, 32'h00001234, 1'b0);
    txn("lh_40", 1'b0, 3'b001, 32'h40, 32'h0, 32'hFFFFAB78, 1'b0);
    txn("lhu_40", 1'b0, 3'b101, 32'h40, 32'h0, 32'h0000AB78, 1'b0);

    // Error cases must not touch storage.
    txn("sh_43_misaligned", 1'b1, 3'b001, 32'h43, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn("sw_42_misaligned", 1'b1, 3'b010, 32'h42, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn("lw_1000_range", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
    txn("ld_f3_011", 1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1);
    txn("st_f3_100", 1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn("lw_40_after_errs", 1'b0, 3'b010, 32'h40, 32'h0, 32'h1234AB78, 1'b0);

    // Stall in RESP while a second request is held valid.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h0;
    tick();
    chk1("stall_accept", req_ready, 1'b0);
    req_funct3 = 3'b100; req_addr = 32'h41;
    wait_resp(lat);
    chk32("stall_latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      chk1("stall_resp_valid", resp_valid, 1'b1);
      chk32("stall_rdata", resp_rdata, 32'h1234AB78);
      chk1("stall_err", resp_err, 1'b0);
      chk1("stall_req_ready", req_ready, 1'b0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk1("stall_release_valid", resp_valid, 1'b0);
    chk32("stall_release_rdata", resp_rdata, 32'h0);
    chk1("stall_no_accept_on_handshake", req_ready, 1'b1);
    tick();
    chk1("stall_second_accept", req_ready, 1'b0);
    req_valid = 1'b0;
    wait_resp(lat);
    chk32("second_latency", 32'(lat), 32'd2);
    chk32("second_rdata", resp_rdata, 32'h000000AB);
    handshake();

    // Reset mid-cycle during WAIT of a store: the store must be dropped.
    issue(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
    #3 rst = 1'b0;
    #1;
    chk1("rst_wait_req_ready", req_ready, 1'b1);
    chk1("rst_wait_resp_valid", resp_valid, 1'b0);
    chk32("rst_wait_rdata", resp_rdata, 32'h0);
    #2 rst = 1'b1;
    tick();
    txn("lw_40_after_rst", 1'b0, 3'b010, 32'h40, 32'h0, 32'h1234AB78, 1'b0);

    // Reset mid-cycle during RESP clears the held response without a clock edge.
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    wait_resp(lat);
    chk32("rst_resp_rdata_before", resp_rdata, 32'h1234AB78);
    #3 rst = 1'b0;
    #1;
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk32("rst_resp_rdata", resp_rdata, 32'h0);
    chk1("rst_resp_req_ready", req_ready, 1'b1);
    #2 rst = 1'b1;
    tick();

    // LATENCY=1, req_valid and resp_ready held high: accept, respond, handshake every 3 edges.
    b_resp_ready = 1'b1;
    b_req_valid  = 1'b1;
    b_req_we = bt_we[0]; b_req_funct3 = bt_f3[0]; b_req_addr = bt_addr[0]; b_req_wdata = bt_wdata[0];
    for (int i = 0; i < 6; i++) begin
      chk1("b2b_ready_idle", b_req_ready, 1'b1);
      tick();
      chk1("b2b_accepted", b_req_ready, 1'b0);
      chk1("b2b_no_early_resp", b_resp_valid, 1'b0);
      tick();
      chk1("b2b_resp_valid", b_resp_valid, 1'b1);
      chk32("b2b_rdata", b_resp_rdata, bt_exp[i]);
      chk1("b2b_err", b_resp_err, 1'b0);
      if (i < 5) begin
        b_req_we = bt_we[i+1]; b_req_funct3 = bt_f3[i+1];
        b_req_addr = bt_addr[i+1]; b_req_wdata = bt_wdata[i+1];
      end
      tick();
      chk1("b2b_handshake", b_resp_valid, 1'b0);
    end
    chk1("b2b_final_idle", b_req_ready, 1'b1);
    b_req_valid  = 1'b0;
    b_resp_ready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in storage; always a power of two.
REQ-002 SHALL have parameter LATENCY, default 2, meaning rising edges from the accepting edge to resp_valid high; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 selects store, 0 selects load.
REQ-008 SHALL have port req_funct3, input, 3 bits: RV32I size/sign code.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: response present.
REQ-012 SHALL have port resp_ready, input, 1 bit: initiator takes the response.
REQ-013 SHALL have port resp_rdata, output, 32 bits: load result, already extended.
REQ-014 SHALL have port resp_err, output, 1 bit: the request was misaligned, out of range or had an illegal funct3.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL accept a request on an edge where the state is IDLE and req_valid=1; on that edge it captures we, funct3, addr and wdata, loads cnt=LATENCY and enters WAIT.
REQ-017 SHALL ignore all req_* inputs outside the accepting edge.
REQ-018 SHALL, in WAIT, decrement cnt each edge; on the edge where cnt==1 it executes the access and enters RESP, so resp_valid rises exactly LATENCY edges after acceptance.
REQ-019 SHALL hold resp_valid=1, with resp_rdata and resp_err stable, throughout RESP; on an edge with resp_ready=1 it returns to IDLE and clears resp_valid, resp_rdata and resp_err.
REQ-020 SHALL NOT accept a new request on the edge that leaves RESP; acceptance is possible at the earliest one edge later.
REQ-021 SHALL treat loads as follows: funct3 000=LB, 001=LH, 010=LW, 100=LBU, 101=LHU; any other load funct3 is illegal.
REQ-022 SHALL treat stores as follows: funct3 000=SB, 001=SH, 010=SW; any other store funct3 is illegal.
REQ-023 SHALL use word index = addr[log2(DEPTH_WORDS)+1:2]; any nonzero addr bit above that field is out of range.
REQ-024 SHALL flag as misaligned: halfword access with addr[0]=1, and word access with addr[1:0]!=00.
REQ-025 SHALL, on error, set resp_err=1 and resp_rdata=0 and leave storage unmodified; it still observes the full LATENCY.
REQ-026 SHALL write SB as wdata[7:0] into lane addr[1:0], SH as wdata[15:0] into lane addr[1], and SW as the whole word; other lanes are unchanged.
REQ-027 SHALL select the byte or halfword lane for loads by addr[1:0]; LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend.
REQ-028 SHALL return load data sampled at the execute edge, so a load returns every store completed before it.
REQ-029 SHALL NOT initialise or clear storage on reset; contents are undefined until written.

Reset
REQ-030 SHALL, while rst=0, immediately force the state to IDLE, cnt=0, req_ready=1, and resp_valid=0, resp_rdata=0, resp_err=0, independent of clk.
REQ-031 SHALL discard any request in WAIT when reset asserts; a pending store SHALL NOT reach storage.
REQ-032 SHALL accept a request no earlier than the first rising edge after rst returns to 1.

Verification
REQ-033 SHALL cover: LATENCY=2, SW 0x12345678 at 0x40, then LW at 0x40 -> rdata 0x12345678 and err 0; resp_valid rises 2 edges after each accept.
REQ-034 SHALL cover: SB wdata 0x000000AB at 0x41 -> LW at 0x40 returns 0x1234AB78, LB at 0x41 returns 0xFFFFFFAB, LBU at 0x41 returns 0x000000AB, LH at 0x42 returns 0x00001234.
REQ-035 SHALL cover: SH at 0x43, SW at 0x42, and LW at 0x1000 (DEPTH_WORDS=1024) -> err 1 and rdata 0 for each; a following LW at 0x40 still returns 0x1234AB78.
REQ-036 SHALL cover: resp_ready held 0 for 5 cycles in RESP while req_valid=1 -> resp_valid, rdata and err stay stable, req_ready=0, and no second request is accepted until one edge after the handshake.
REQ-037 SHALL cover: reset asserted mid-cycle during WAIT of SW 0xDEADBEEF at 0x40 -> outputs clear without a clock edge; after release, LW at 0x40 returns 0x1234AB78.
REQ-038 SHALL cover: LATENCY=1 and back-to-back requests with req_valid held high and resp_ready=1 -> one accept every 3 edges, and each response matches its request.
